// File: rtl/key_controls.sv
// Turns the decoded PS/2 make/brake stream into player controls:
// resolved left/right movement, auto-repeating fire pulses and a pause toggle.
module key_controls #(
    parameter logic [8:0] KEY_LEFT      = 9'h16B,
    parameter logic [8:0] KEY_RIGHT     = 9'h174,
    parameter logic [8:0] KEY_FIRE      = 9'h029,
    parameter logic [8:0] KEY_PAUSE     = 9'h04D,
    parameter int         REPEAT_FIRST  = 25000000,
    parameter int         REPEAT_PERIOD = 12500000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [8:0] keyCode,
    input  logic       make,
    input  logic       brake,
    output logic       move_left,
    output logic       move_right,
    output logic       fire_pulse,
    output logic       pause,
    output logic       key_event
);

    localparam int CNT_MAX = (REPEAT_FIRST > REPEAT_PERIOD) ? REPEAT_FIRST : REPEAT_PERIOD;
    localparam int CNT_W   = $clog2(CNT_MAX);
    localparam logic [CNT_W-1:0] FIRST_LOAD  = CNT_W'(REPEAT_FIRST - 1);
    localparam logic [CNT_W-1:0] PERIOD_LOAD = CNT_W'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {IDLE, FIRST, REPEAT} fire_state_t;

    fire_state_t      fire_state;
    logic [CNT_W-1:0] fire_cnt;
    logic             left_held, right_held, fire_held, pause_held;
    logic             last_dir;  // 1: right was pressed most recently

    logic make_ok;
    logic press_left, press_right, press_fire, press_pause;
    logic rel_left, rel_right, rel_fire, rel_pause;
    logic left_next, right_next, last_dir_next;

    // brake wins over a simultaneous make; a make on a held key is typematic
    always_comb begin
        make_ok       = make & ~brake;
        press_left    = make_ok & (keyCode == KEY_LEFT)  & ~left_held;
        press_right   = make_ok & (keyCode == KEY_RIGHT) & ~right_held;
        press_fire    = make_ok & (keyCode == KEY_FIRE)  & ~fire_held;
        press_pause   = make_ok & (keyCode == KEY_PAUSE) & ~pause_held;
        rel_left      = brake & (keyCode == KEY_LEFT);
        rel_right     = brake & (keyCode == KEY_RIGHT);
        rel_fire      = brake & (keyCode == KEY_FIRE);
        rel_pause     = brake & (keyCode == KEY_PAUSE);
        left_next     = (left_held  | press_left)  & ~rel_left;
        right_next    = (right_held | press_right) & ~rel_right;
        last_dir_next = press_right ? 1'b1 : (press_left ? 1'b0 : last_dir);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            left_held  <= 1'b0;
            right_held <= 1'b0;
            fire_held  <= 1'b0;
            pause_held <= 1'b0;
            last_dir   <= 1'b0;
            fire_state <= IDLE;
            fire_cnt   <= '0;
            move_left  <= 1'b0;
            move_right <= 1'b0;
            fire_pulse <= 1'b0;
            pause      <= 1'b0;
            key_event  <= 1'b0;
        end else begin
            left_held  <= left_next;
            right_held <= right_next;
            fire_held  <= (fire_held  | press_fire)  & ~rel_fire;
            pause_held <= (pause_held | press_pause) & ~rel_pause;
            last_dir   <= last_dir_next;

            move_left  <= left_next  & (~right_next | ~last_dir_next);
            move_right <= right_next & (~left_next  |  last_dir_next);
            key_event  <= press_left | press_right | press_fire | press_pause;
            if (press_pause)
                pause <= ~pause;

            fire_pulse <= 1'b0;
            case (fire_state)
                IDLE: begin
                    if (press_fire) begin
                        fire_pulse <= 1'b1;
                        fire_cnt   <= FIRST_LOAD;
                        fire_state <= FIRST;
                    end
                end
                FIRST, REPEAT: begin
                    // release takes priority over a coincident expiry
                    if (rel_fire) begin
                        fire_state <= IDLE;
                    end else if (fire_cnt == '0) begin
                        fire_pulse <= 1'b1;
                        fire_cnt   <= PERIOD_LOAD;
                        fire_state <= REPEAT;
                    end else begin
                        fire_cnt <= fire_cnt - CNT_W'(1);
                    end
                end
                default: fire_state <= IDLE;
            endcase
        end
    end

endmodule
